// File: rtl/seg7_ctrl_pkg.sv
// Shared types and constants for the seg7 mode scheduler: FSM encoding,
// request/grant bit positions and the default speed compare settings.
package seg7_ctrl_pkg;

  typedef enum logic {
    MANUAL = 1'b0,
    DEMO   = 1'b1
  } state_t;

  localparam int unsigned N_REQ       = 4;
  localparam int unsigned GNT_ANI_INC = 0;
  localparam int unsigned GNT_ANI_DEC = 1;
  localparam int unsigned GNT_SPD_INC = 2;
  localparam int unsigned GNT_SPD_DEC = 3;

  localparam int unsigned ANI_BIT_VAL     = 6;
  localparam int unsigned COUNTER_BIT_VAL = 25;
  localparam int unsigned CMP_DEFAULT_VAL = 10_000_000;
  localparam int unsigned CMP_STEP_VAL    = 1_000_000;
  localparam int unsigned CMP_MIN_VAL     = 1_000_000;
  localparam int unsigned CMP_MAX_VAL     = 19_000_000;
  localparam int unsigned IDLE_WRAPS_VAL  = 16;
  localparam int unsigned DEMO_WRAPS_VAL  = 4;

endpackage

// File: rtl/seg7_rr_arb4.sv
// Four-way round-robin arbiter: picks the first pending bit at or after ptr
// and returns the one-hot grant plus the pointer to use after that grant.
module seg7_rr_arb4 (
  input  logic [3:0] pending,
  input  logic [1:0] ptr,
  output logic [3:0] grant_next,
  output logic [1:0] ptr_next
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    grant_next = '0;
    ptr_next   = ptr;
    found      = 1'b0;
    idx        = '0;
    for (int i = 0; i < 4; i++) begin
      idx = 2'(ptr + 2'(i));
      if (!found && pending[idx]) begin
        found           = 1'b1;
        grant_next[idx] = 1'b1;
        ptr_next        = 2'(idx + 2'd1);
      end
    end
  end

endmodule

// File: rtl/seg7_mode_sched.sv
// Owns the animation index and speed compare value: button edge capture,
// round-robin application of one change per cycle, and an idle-driven demo mode.
module seg7_mode_sched
  import seg7_ctrl_pkg::*;
#(
  parameter int unsigned ANI_BIT     = ANI_BIT_VAL,
  parameter int unsigned COUNTER_BIT = COUNTER_BIT_VAL,
  parameter int unsigned CMP_DEFAULT = CMP_DEFAULT_VAL,
  parameter int unsigned CMP_STEP    = CMP_STEP_VAL,
  parameter int unsigned CMP_MIN     = CMP_MIN_VAL,
  parameter int unsigned CMP_MAX     = CMP_MAX_VAL,
  parameter int unsigned IDLE_WRAPS  = IDLE_WRAPS_VAL,
  parameter int unsigned DEMO_WRAPS  = DEMO_WRAPS_VAL
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn_ani_inc,
  input  logic                   btn_ani_dec,
  input  logic                   btn_spd_inc,
  input  logic                   btn_spd_dec,
  input  logic                   wrap_tick,
  input  logic                   demo_en,
  output logic [ANI_BIT-1:0]     animation,
  output logic [COUNTER_BIT-1:0] compare,
  output logic                   cfg_update,
  output logic [3:0]             grant,
  output logic                   demo_active
);

  localparam int unsigned CW     = COUNTER_BIT + 1;
  localparam int unsigned IDLE_W = $clog2(IDLE_WRAPS + 1);
  localparam int unsigned DEMO_W = $clog2(DEMO_WRAPS + 1);

  logic [3:0]             btn_c;
  logic [3:0]             btn_s;
  logic [3:0]             btn_q;
  logic [3:0]             btn_edge_c;
  logic [3:0]             pending;
  logic [1:0]             rr_ptr;
  logic [3:0]             grant_next;
  logic [1:0]             ptr_next;
  logic                   any_gnt_c;
  logic                   any_edge_c;

  state_t                 state;
  state_t                 state_next;
  logic [IDLE_W-1:0]      idle_cnt;
  logic [IDLE_W-1:0]      idle_cnt_next;
  logic [DEMO_W-1:0]      demo_cnt;
  logic [DEMO_W-1:0]      demo_cnt_next;
  logic                   adv_c;

  logic [ANI_BIT-1:0]     ani_next;
  logic [COUNTER_BIT-1:0] cmp_next;
  logic [CW-1:0]          cmp_ext_c;
  logic                   chg_c;
  logic                   chg_q;

  assign btn_c      = {btn_spd_dec, btn_spd_inc, btn_ani_dec, btn_ani_inc};
  // Edges come from the sampled copy so the raw button never feeds logic directly.
  assign btn_edge_c = btn_s & ~btn_q;
  assign any_gnt_c  = |grant_next;
  assign any_edge_c = |btn_edge_c;
  assign cmp_ext_c  = CW'(compare);
  assign demo_active = (state == DEMO);

  seg7_rr_arb4 u_arb (
    .pending    (pending),
    .ptr        (rr_ptr),
    .grant_next (grant_next),
    .ptr_next   (ptr_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MANUAL;
    else       state <= state_next;
  end

  // Idle/demo bookkeeping; a grant always takes priority over auto-advance.
  always_comb begin
    state_next    = state;
    idle_cnt_next = idle_cnt;
    demo_cnt_next = demo_cnt;
    adv_c         = 1'b0;
    case (state)
      MANUAL: begin
        if (any_gnt_c) begin
          idle_cnt_next = '0;
        end else if (wrap_tick && (idle_cnt < IDLE_W'(IDLE_WRAPS))) begin
          idle_cnt_next = idle_cnt + IDLE_W'(1);
        end
        if (demo_en && !any_gnt_c && (idle_cnt == IDLE_W'(IDLE_WRAPS))) begin
          state_next    = DEMO;
          demo_cnt_next = '0;
        end
      end
      DEMO: begin
        if (any_gnt_c || any_edge_c || !demo_en) begin
          state_next    = MANUAL;
          idle_cnt_next = '0;
          demo_cnt_next = '0;
        end else if (wrap_tick) begin
          if (demo_cnt == DEMO_W'(DEMO_WRAPS - 1)) begin
            demo_cnt_next = '0;
            adv_c         = 1'b1;
          end else begin
            demo_cnt_next = demo_cnt + DEMO_W'(1);
          end
        end
      end
      default: state_next = MANUAL;
    endcase
  end

  // Apply the granted change; saturated speed requests leave compare as is.
  always_comb begin
    ani_next = animation;
    cmp_next = compare;
    chg_c    = 1'b0;
    if (grant_next[GNT_ANI_INC]) begin
      ani_next = animation + ANI_BIT'(1);
      chg_c    = 1'b1;
    end else if (grant_next[GNT_ANI_DEC]) begin
      ani_next = animation - ANI_BIT'(1);
      chg_c    = 1'b1;
    end else if (grant_next[GNT_SPD_INC]) begin
      if ((cmp_ext_c + CW'(CMP_STEP)) <= CW'(CMP_MAX)) begin
        cmp_next = compare + COUNTER_BIT'(CMP_STEP);
        chg_c    = 1'b1;
      end
    end else if (grant_next[GNT_SPD_DEC]) begin
      if (cmp_ext_c >= (CW'(CMP_MIN) + CW'(CMP_STEP))) begin
        cmp_next = compare - COUNTER_BIT'(CMP_STEP);
        chg_c    = 1'b1;
      end
    end else if (adv_c) begin
      ani_next = animation + ANI_BIT'(1);
      chg_c    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s      <= '0;
      btn_q      <= '0;
      pending    <= '0;
      rr_ptr     <= '0;
      grant      <= '0;
      idle_cnt   <= '0;
      demo_cnt   <= '0;
      animation  <= '0;
      compare    <= COUNTER_BIT'(CMP_DEFAULT);
      chg_q      <= 1'b0;
      cfg_update <= 1'b0;
    end else begin
      btn_s      <= btn_c;
      btn_q      <= btn_s;
      pending    <= (pending & ~grant_next) | btn_edge_c;
      rr_ptr     <= ptr_next;
      grant      <= grant_next;
      idle_cnt   <= idle_cnt_next;
      demo_cnt   <= demo_cnt_next;
      animation  <= ani_next;
      compare    <= cmp_next;
      chg_q      <= chg_c;
      cfg_update <= chg_q;
    end
  end

endmodule

// File: doc/seg7_mode_sched.md
Name: seg7_mode_sched

Overview:
Controller that owns the animation index and the speed compare value for the 7-segment animation datapath.
- Takes four debounced button levels from the debouncers. Converts each to a single request event on its rising edge.
- Arbitrates pending events round-robin, so at most one configuration change is applied per cycle.
- Runs a demo-mode FSM that auto-advances the animation after a period of user inactivity.
- Outputs drive the existing seg7/changing datapath directly, replacing the per-button next-state logic.

Parameters:
- ANI_BIT, 6, width of the animation index; the index wraps 0 <-> 2^ANI_BIT-1.
- COUNTER_BIT, 25, width of the compare value.
- CMP_DEFAULT, 10_000_000, compare value after reset (1 s at 10 MHz).
- CMP_STEP, 1_000_000, compare change per speed event.
- CMP_MIN, 1_000_000, lowest legal compare value.
- CMP_MAX, 19_000_000, highest legal compare value.
- IDLE_WRAPS, 16, number of wrap_tick pulses without a granted event before demo mode is entered.
- DEMO_WRAPS, 4, number of wrap_tick pulses between automatic animation advances in demo mode.

Ports:
- clk  in  1  system clock (10 MHz).
- reset  in  1  asynchronous, active-high reset.
- btn_ani_inc  in  1  debounced level: next animation.
- btn_ani_dec  in  1  debounced level: previous animation.
- btn_spd_inc  in  1  debounced level: compare + CMP_STEP (slower).
- btn_spd_dec  in  1  debounced level: compare - CMP_STEP (faster).
- wrap_tick  in  1  one-cycle pulse from the datapath when the digit counter wraps to 0.
- demo_en  in  1  level; enables demo mode.
- animation  out  ANI_BIT  current animation index.
- compare  out  COUNTER_BIT  current speed compare value.
- cfg_update  out  1  one-cycle pulse, the cycle after animation or compare changes.
- grant  out  4  one-hot registered grant, bit order {spd_dec, spd_inc, ani_dec, ani_inc}.
- demo_active  out  1  high while the FSM is in DEMO.

Behaviour:
- Reset, asynchronous and active-high; all registered:
  - animation=0, compare=CMP_DEFAULT, cfg_update=0, grant=0, demo_active=0.
  - Button sample registers=0, pending=0, round-robin pointer=0, idle/demo counters=0, state=MANUAL.
- Edge detect:
  - btn_q <= btn each cycle; edge = btn & ~btn_q.
  - A held button produces exactly one event, with no auto-repeat.
- Pending:
  - pending <= (pending & ~grant_next) | edge.
  - An edge arriving in the same cycle its source is granted leaves pending set. This cannot occur in practice (edge requires the previous level low), but the rule is fixed.
- Arbiter:
  - Round-robin over pending bits 0..3, starting at the pointer.
  - After granting bit i, the pointer becomes (i+1) mod 4. The pointer is unchanged when nothing is granted.
  - grant is registered, and animation/compare update in that same cycle.
- Latency: a button goes high before edge k, its pending bit sets at edge k+1, and grant plus the new value appear at edge k+2. An uncontended event therefore takes 2 cycles.
- Apply rules:
  - ani_inc: index +1, wrapping max->0.
  - ani_dec: index -1, wrapping 0->max.
  - spd_inc: compare += CMP_STEP only if compare+CMP_STEP <= CMP_MAX; otherwise unchanged.
  - spd_dec: compare -= CMP_STEP only if compare-CMP_STEP >= CMP_MIN; otherwise unchanged. Compare the sums at COUNTER_BIT+1 width.
  - A saturated grant still pulses grant, but not cfg_update.
- FSM states:
  - MANUAL:
    - idle_cnt increments on wrap_tick, saturating at IDLE_WRAPS.
    - Any grant clears idle_cnt.
    - When demo_en=1 and idle_cnt reaches IDLE_WRAPS, go to DEMO and clear demo_cnt.
  - DEMO:
    - demo_active=1.
    - demo_cnt increments on wrap_tick. On reaching DEMO_WRAPS it clears, animation +1 with wrap, and cfg_update pulses.
    - Any edge, or demo_en=0, returns to MANUAL and clears idle_cnt.
    - The edge's event is still served normally.
- Simultaneous events:
  - A grant and a demo auto-advance in the same cycle: the grant wins, the auto-advance is dropped, and the FSM exits.
  - wrap_tick and a grant in the same cycle in MANUAL: idle_cnt is cleared.
- Reset mid-operation clears pending events; no event survives reset.

Decomposition:
- Package seg7_ctrl_pkg holds:
  - state encoding: MANUAL=1'b0, DEMO=1'b1;
  - grant bit indices: GNT_ANI_INC=0, GNT_ANI_DEC=1, GNT_SPD_INC=2, GNT_SPD_DEC=3;
  - the CMP_* default constants.
- One sub-module, seg7_rr_arb4:
  - inputs: pending[3:0] and the pointer;
  - outputs: combinational one-hot grant_next and next pointer.

Test Plan:
- Pulse btn_ani_inc high for 5 cycles after reset -> animation 0->1 exactly once, 2 cycles after the rise; cfg_update one cycle after; grant=4'b0001 for one cycle.
- At animation=0, press btn_ani_dec -> animation=63. At 63, press btn_ani_inc -> 0.
- Compare at CMP_MAX=19_000_000, press btn_spd_inc -> compare unchanged, grant=4'b0100, no cfg_update. Compare at 1_000_000, press btn_spd_dec -> unchanged.
- Raise all four buttons in the same cycle after reset -> grants 0001, 0010, 0100, 1000 on consecutive cycles. Final state: animation=0, compare=10_000_000, with 4 cycles in which cfg_update is asserted.
- demo_en=1 with 16 wrap_ticks and no buttons -> demo_active=1. Every 4th subsequent tick advances animation by 1. Pressing btn_spd_dec then gives demo_active=0 and compare=9_000_000.
- Assert reset while a pending ani_inc is outstanding -> after release animation=0, grant=0, no cfg_update.
